// File: rtl/mprj_io_cfg_pkg.sv
// Shared types and constants for the mprj_io pad configuration loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: loader FSM state enum, default word width and reset word,
// and the bit positions of the fields inside one pad configuration word.
package mprj_io_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } ld_state_t;

  localparam int          CFG_BITS_DEF  = 13;
  localparam logic [12:0] CFG_RESET_DEF = 13'h0403;

  // Field layout of one pad word. The reset word selects management
  // control, enables the output driver and sets drive strength 1.
  localparam int CFG_MGMT_SEL_BIT  = 0;
  localparam int CFG_OUT_EN_BIT    = 1;
  localparam int CFG_INP_EN_BIT    = 2;
  localparam int CFG_PULLUP_BIT    = 3;
  localparam int CFG_PULLDOWN_BIT  = 4;
  localparam int CFG_SCHMITT_BIT   = 5;
  localparam int CFG_SLEW_BIT      = 6;
  localparam int CFG_DRIVE_LSB     = 10;
  localparam int CFG_DRIVE_MSB     = 11;

endpackage

// File: rtl/mprj_io_cfg_regs.sv
// Per-pad configuration word array with one write port and a readback port.
// Latency: writes land on the next edge; readback is registered (1 cycle).
// Backpressure: none; writes while blocked or out of range are dropped and flagged.
//
// Ports: clock/reset (sync, active-high); wr_block (loader busy), wr_en,
// addr, wr_data in; rd_data, wr_err (1-cycle pulse) out; words = whole
// array flattened, word i at bits [i*CFG_BITS +: CFG_BITS].
module mprj_io_cfg_regs
  import mprj_io_cfg_pkg::*;
#(
  parameter int                  NUM_PADS  = 38,
  parameter int                  CFG_BITS  = CFG_BITS_DEF,
  parameter logic [CFG_BITS-1:0] CFG_RESET = CFG_BITS'(CFG_RESET_DEF)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_block,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_PADS)-1:0]  addr,
  input  logic [CFG_BITS-1:0]          wr_data,
  output logic [CFG_BITS-1:0]          rd_data,
  output logic                         wr_err,
  output logic [NUM_PADS*CFG_BITS-1:0] words
);

  localparam int AW = $clog2(NUM_PADS);

  logic [CFG_BITS-1:0] mem [NUM_PADS];
  logic                addr_ok;

  // Address space is a power of two; pads above NUM_PADS-1 do not exist.
  assign addr_ok = {1'b0, addr} < (AW+1)'(NUM_PADS);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PADS; i++) mem[i] <= CFG_RESET;
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && (wr_block || !addr_ok);
      if (wr_en && !wr_block && addr_ok) mem[addr] <= wr_data;
      rd_data <= addr_ok ? mem[addr] : '0;
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_flat
    assign words[g*CFG_BITS +: CFG_BITS] = mem[g];
  end

endmodule

// File: rtl/mprj_io_config_loader.sv
// Serial loader shifting every pad word out over NUM_CHAINS daisy chains, then strobing load.
// Latency: busy one cycle after start; done at cycle 1+2*B*CLK_DIV+CLK_DIV.
// Backpressure: start ignored and config writes rejected (cfg_wr_err) while a load runs.
//
// Ports: clock/reset (sync, active-high); cfg_wr_en/cfg_addr/cfg_wr_data
// write port, cfg_rd_data registered readback, cfg_wr_err reject pulse;
// start/busy/done load handshake; serial_clock/serial_load/serial_data chains.
module mprj_io_config_loader
  import mprj_io_cfg_pkg::*;
#(
  parameter int                  NUM_PADS   = 38,
  parameter int                  NUM_CHAINS = 2,
  parameter int                  CFG_BITS   = CFG_BITS_DEF,
  parameter int                  CLK_DIV    = 4,
  parameter logic [CFG_BITS-1:0] CFG_RESET  = CFG_BITS'(CFG_RESET_DEF)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_wr_en,
  input  logic [$clog2(NUM_PADS)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]         cfg_wr_data,
  output logic [CFG_BITS-1:0]         cfg_rd_data,
  output logic                        cfg_wr_err,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        serial_clock,
  output logic                        serial_load,
  output logic [NUM_CHAINS-1:0]       serial_data
);

  localparam int PPC = NUM_PADS / NUM_CHAINS;
  localparam int B   = PPC * CFG_BITS;
  localparam int HCW = $clog2(CLK_DIV + 1);
  localparam int BCW = $clog2(B + 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(B - 1);

  ld_state_t                    state, state_nx;
  logic [HCW-1:0]               hc, hc_nx;
  logic [BCW-1:0]               bc, bc_nx;
  logic [BCW-1:0]               rev;
  logic                         shifting;
  logic [NUM_PADS*CFG_BITS-1:0] words;

  mprj_io_cfg_regs #(
    .NUM_PADS  (NUM_PADS),
    .CFG_BITS  (CFG_BITS),
    .CFG_RESET (CFG_RESET)
  ) u_regs (
    .clock    (clock),
    .reset    (reset),
    .wr_block (state != IDLE),
    .wr_en    (cfg_wr_en),
    .addr     (cfg_addr),
    .wr_data  (cfg_wr_data),
    .rd_data  (cfg_rd_data),
    .wr_err   (cfg_wr_err),
    .words    (words)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      hc    <= '0;
      bc    <= '0;
    end else begin
      state <= state_nx;
      hc    <= hc_nx;
      bc    <= bc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hc_nx    = hc;
    bc_nx    = bc;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT_LO;
          hc_nx    = '0;
          bc_nx    = '0;
        end
      end
      SHIFT_LO: begin
        if (hc == HC_LAST) begin
          hc_nx    = '0;
          state_nx = SHIFT_HI;
        end else begin
          hc_nx = hc + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (hc == HC_LAST) begin
          hc_nx = '0;
          if (bc == BC_LAST) begin
            bc_nx    = '0;
            state_nx = LOAD;
          end else begin
            bc_nx    = bc + 1'b1;
            state_nx = SHIFT_LO;
          end
        end else begin
          hc_nx = hc + 1'b1;
        end
      end
      LOAD: begin
        if (hc == HC_LAST) begin
          hc_nx    = '0;
          state_nx = DONE;
        end else begin
          hc_nx = hc + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy         = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LOAD);
  assign done         = (state == DONE);
  assign serial_clock = (state == SHIFT_HI);
  assign serial_load  = (state == LOAD);
  assign shifting     = (state == SHIFT_LO) || (state == SHIFT_HI);

  // A chain's words sit contiguously in the flat array with its highest pad
  // at the top, so bit k of the stream is chain slice bit B-1-k.
  assign rev = BC_LAST - bc;

  always_comb begin
    serial_data = '0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      for (int j = 0; j < B; j++) begin
        if (shifting && (rev == BCW'(j))) serial_data[c] = words[c*B + j];
      end
    end
  end

endmodule

// File: tb/tb_mprj_io_config_loader.sv
// Bench for mprj_io_config_loader: small instance (4 pads, 4 bits, CLK_DIV=1)
// and default-sized instance (38 pads, 13 bits, CLK_DIV=3) on one clock.
// Expected serial bits are queued from a word model when start is driven.
module tb_mprj_io_config_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic       a_wr_en, a_err, a_start, a_busy, a_done, a_sclk, a_sload;
  logic [1:0] a_addr, a_sdata;
  logic [3:0] a_wdata, a_rdata;

  logic        b_wr_en, b_err, b_start, b_busy, b_done, b_sclk, b_sload;
  logic [5:0]  b_addr;
  logic [1:0]  b_sdata;
  logic [12:0] b_wdata, b_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  a_q [$];
  logic [1:0]  b_q [$];
  logic [3:0]  a_model [4];
  logic [12:0] b_model [38];

  mprj_io_config_loader #(
    .NUM_PADS(4), .NUM_CHAINS(2), .CFG_BITS(4), .CLK_DIV(1), .CFG_RESET(4'h3)
  ) u_a (
    .clock(clock), .reset(reset), .cfg_wr_en(a_wr_en), .cfg_addr(a_addr),
    .cfg_wr_data(a_wdata), .cfg_rd_data(a_rdata), .cfg_wr_err(a_err),
    .start(a_start), .busy(a_busy), .done(a_done), .serial_clock(a_sclk),
    .serial_load(a_sload), .serial_data(a_sdata)
  );

  mprj_io_config_loader #(
    .NUM_PADS(38), .NUM_CHAINS(2), .CFG_BITS(13), .CLK_DIV(3), .CFG_RESET(13'h0403)
  ) u_b (
    .clock(clock), .reset(reset), .cfg_wr_en(b_wr_en), .cfg_addr(b_addr),
    .cfg_wr_data(b_wdata), .cfg_rd_data(b_rdata), .cfg_wr_err(b_err),
    .start(b_start), .busy(b_busy), .done(b_done), .serial_clock(b_sclk),
    .serial_load(b_sload), .serial_data(b_sdata)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic models_reset;
    for (int i = 0; i < 4; i++) a_model[i] = 4'h3;
    for (int i = 0; i < 38; i++) b_model[i] = 13'h0403;
  endtask

  // Chain c carries pads c*PPC..c*PPC+PPC-1; highest pad first, MSB first.
  task automatic push_a;
    logic [1:0] e;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 2; c++) e[c] = a_model[c*2 + 1 - k/4][3 - k%4];
      a_q.push_back(e);
    end
  endtask

  task automatic push_b;
    logic [1:0] e;
    for (int k = 0; k < 247; k++) begin
      for (int c = 0; c < 2; c++) e[c] = b_model[c*19 + 18 - k/13][12 - k%13];
      b_q.push_back(e);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_wr_en = 0; a_addr = 0; a_wdata = 0; a_start = 0;
    b_wr_en = 0; b_addr = 0; b_wdata = 0; b_start = 0;
    tick; tick;
    models_reset();
    n_checks++;
    if ({a_busy, a_done, a_err, a_sclk, a_sload, a_sdata, a_rdata} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got %b expected all 0",
               {a_busy, a_done, a_err, a_sclk, a_sload, a_sdata, a_rdata});
    end
    n_checks++;
    if ({b_busy, b_done, b_err, b_sclk, b_sload, b_sdata, b_rdata} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got %b expected all 0",
               {b_busy, b_done, b_err, b_sclk, b_sload, b_sdata, b_rdata});
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_addr = 2'(i);
      b_addr = 6'(i);
      tick;
      n_checks++;
      if (a_rdata !== 4'h3) begin
        n_fail++;
        $display("FAIL reset_word_a[%0d]: got %h expected 3", i, a_rdata);
      end
    end
    n_checks++;
    if (b_rdata !== 13'h0403) begin
      n_fail++;
      $display("FAIL reset_word_b[3]: got %h expected 0403", b_rdata);
    end
  endtask

  task automatic test_shift;
    int rises, load_cyc, done_cyc, cyc;
    logic prev_sclk;
    logic [1:0] prev_sd, e;
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_addr = 2'(i); a_wdata = 4'(i + 1);
      tick;
      a_wr_en = 0;
      a_model[i] = 4'(i + 1);
      n_checks++;
      if (a_err !== 1'b0) begin
        n_fail++;
        $display("FAIL write_err_idle[%0d]: got %b expected 0", i, a_err);
      end
    end
    for (int i = 0; i < 4; i++) begin
      a_addr = 2'(i);
      tick;
      n_checks++;
      if (a_rdata !== a_model[i]) begin
        n_fail++;
        $display("FAIL readback[%0d]: got %h expected %h", i, a_rdata, a_model[i]);
      end
    end
    push_a();
    a_start = 1;
    tick;
    a_start = 0;
    n_checks++;
    if (a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_cycle1: got %b expected 1", a_busy);
    end
    rises = 0; load_cyc = -1; done_cyc = -1; cyc = 1;
    prev_sclk = 0; prev_sd = 0;
    while (done_cyc < 0 && cyc <= 40) begin
      if (a_sclk && !prev_sclk) begin
        rises++;
        e = (a_q.size() > 0) ? a_q.pop_front() : 2'bxx;
        n_checks++;
        if (a_sdata !== e) begin
          n_fail++;
          $display("FAIL shift_bit[%0d]: got %b expected %b", rises - 1, a_sdata, e);
        end
        n_checks++;
        if (a_sdata !== prev_sd) begin
          n_fail++;
          $display("FAIL data_stable[%0d]: got %b at rise, %b before", rises - 1, a_sdata, prev_sd);
        end
      end
      if (a_sload && load_cyc < 0) begin
        load_cyc = cyc;
        n_checks++;
        if ({a_sclk, a_sdata} !== 3'b0) begin
          n_fail++;
          $display("FAIL load_quiet: got clk/data %b expected 000", {a_sclk, a_sdata});
        end
      end
      if (a_done) begin
        done_cyc = cyc;
        n_checks++;
        if (a_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_at_done: got %b expected 0", a_busy);
        end
      end
      prev_sclk = a_sclk;
      prev_sd = a_sdata;
      tick;
      cyc++;
    end
    n_checks++;
    if (rises != 8) begin n_fail++; $display("FAIL rise_count: got %0d expected 8", rises); end
    n_checks++;
    if (load_cyc != 17) begin n_fail++; $display("FAIL load_cycle: got %0d expected 17", load_cyc); end
    n_checks++;
    if (done_cyc != 18) begin n_fail++; $display("FAIL done_cycle: got %0d expected 18", done_cyc); end
    n_checks++;
    if ({a_busy, a_done} !== 2'b0) begin
      n_fail++;
      $display("FAIL idle_after_done: got busy/done %b expected 00", {a_busy, a_done});
    end
  endtask

  task automatic test_write_busy;
    int wait_cyc;
    a_start = 1;
    tick;
    a_start = 0;
    tick; tick;
    a_wr_en = 1; a_addr = 2; a_wdata = 4'hF;
    tick;
    a_wr_en = 0;
    n_checks++;
    if (a_err !== 1'b1) begin n_fail++; $display("FAIL busy_write_err: got %b expected 1", a_err); end
    tick;
    n_checks++;
    if (a_err !== 1'b0) begin n_fail++; $display("FAIL busy_write_err_pulse: got %b expected 0", a_err); end
    wait_cyc = 0;
    while (a_done !== 1'b1 && wait_cyc < 40) begin tick; wait_cyc++; end
    n_checks++;
    if (a_done !== 1'b1) begin n_fail++; $display("FAIL busy_load_done: got %b expected 1", a_done); end
    tick;
    a_addr = 2;
    tick;
    n_checks++;
    if (a_rdata !== a_model[2]) begin
      n_fail++;
      $display("FAIL busy_write_ignored: got %h expected %h", a_rdata, a_model[2]);
    end
    b_wr_en = 1; b_addr = 6'd40; b_wdata = 13'h1FFF;
    tick;
    b_wr_en = 0;
    n_checks++;
    if (b_err !== 1'b1) begin n_fail++; $display("FAIL range_write_err: got %b expected 1", b_err); end
    tick;
    n_checks++;
    if (b_err !== 1'b0) begin n_fail++; $display("FAIL range_write_err_pulse: got %b expected 0", b_err); end
    n_checks++;
    if (b_rdata !== 13'h0) begin n_fail++; $display("FAIL range_read_zero: got %h expected 0", b_rdata); end
    b_wr_en = 1; b_addr = 6'd37; b_wdata = 13'h1ABC;
    tick;
    b_wr_en = 0;
    b_model[37] = 13'h1ABC;
    n_checks++;
    if (b_err !== 1'b0) begin n_fail++; $display("FAIL b_write_ok_err: got %b expected 0", b_err); end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    a_start = 1;
    tick;
    a_start = 0;
    repeat (6) tick;
    reset = 1;
    tick;
    models_reset();
    n_checks++;
    if ({a_busy, a_done, a_err, a_sclk, a_sload, a_sdata} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b expected all 0",
               {a_busy, a_done, a_err, a_sclk, a_sload, a_sdata});
    end
    reset = 0;
    seen_done = 0;
    repeat (20) begin
      tick;
      if (a_done === 1'b1 || a_busy === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %0d busy/done cycles expected 0", seen_done);
    end
    a_addr = 0;
    b_addr = 37;
    tick;
    n_checks++;
    if (a_rdata !== a_model[0]) begin
      n_fail++;
      $display("FAIL mid_reset_word_a0: got %h expected %h", a_rdata, a_model[0]);
    end
    n_checks++;
    if (b_rdata !== b_model[37]) begin
      n_fail++;
      $display("FAIL mid_reset_word_b37: got %h expected %h", b_rdata, b_model[37]);
    end
  endtask

  task automatic test_back_to_back;
    int dcount, d1, d2;
    dcount = 0; d1 = -1; d2 = -1;
    a_start = 1;
    tick;
    for (int cyc = 1; cyc <= 38; cyc++) begin
      if (a_done === 1'b1) begin
        dcount++;
        if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc;
      end
      if (cyc == 19) begin
        n_checks++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected 0", a_busy); end
      end
      if (cyc == 20) begin
        n_checks++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_rise: got %b expected 1", a_busy); end
      end
      if (cyc == 37) a_start = 0;
      tick;
    end
    n_checks++;
    if (dcount != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", dcount); end
    n_checks++;
    if (d1 != 18 || d2 != 37) begin
      n_fail++;
      $display("FAIL b2b_done_cycles: got %0d,%0d expected 18,37", d1, d2);
    end
    n_checks++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got %b expected 0", a_busy); end
  endtask

  task automatic test_slow_wide;
    int rises, load_cyc, done_cyc, cyc, run, phases, bad_phase, bad_bit, first_bad;
    logic prev_sclk;
    logic [1:0] prev_sd, e;
    for (int i = 0; i < 38; i += 3) begin
      b_wr_en = 1; b_addr = 6'(i); b_wdata = 13'($urandom_range(0, 8191));
      b_model[i] = b_wdata;
      tick;
    end
    b_wr_en = 0;
    push_b();
    b_start = 1;
    tick;
    b_start = 0;
    rises = 0; load_cyc = -1; done_cyc = -1; cyc = 1;
    run = 0; phases = 0; bad_phase = 0; bad_bit = 0; first_bad = -1;
    prev_sclk = 0; prev_sd = 0;
    while (done_cyc < 0 && cyc <= 1600) begin
      if (b_busy && !b_sload) begin
        if (b_sclk == prev_sclk) run++;
        else begin
          phases++;
          if (run != 3) bad_phase++;
          run = 1;
        end
      end
      if (b_sclk && !prev_sclk) begin
        rises++;
        e = (b_q.size() > 0) ? b_q.pop_front() : 2'bxx;
        if (b_sdata !== e || b_sdata !== prev_sd) begin
          bad_bit++;
          if (first_bad < 0) first_bad = rises - 1;
        end
      end
      if (b_sload && load_cyc < 0) begin
        load_cyc = cyc;
        phases++;
        if (run != 3) bad_phase++;
      end
      if (b_done) done_cyc = cyc;
      prev_sclk = b_sclk;
      prev_sd = b_sdata;
      tick;
      cyc++;
    end
    n_checks++;
    if (bad_bit != 0) begin
      n_fail++;
      $display("FAIL wide_bits: got %0d wrong bits (first at %0d) expected 0", bad_bit, first_bad);
    end
    n_checks++;
    if (bad_phase != 0 || phases != 494) begin
      n_fail++;
      $display("FAIL wide_phases: got %0d phases, %0d not 3 cycles; expected 494, 0", phases, bad_phase);
    end
    n_checks++;
    if (rises != 247) begin n_fail++; $display("FAIL wide_rises: got %0d expected 247", rises); end
    n_checks++;
    if (load_cyc != 1483) begin n_fail++; $display("FAIL wide_load_cycle: got %0d expected 1483", load_cyc); end
    n_checks++;
    if (done_cyc != 1486) begin n_fail++; $display("FAIL wide_done_cycle: got %0d expected 1486", done_cyc); end
    n_checks++;
    if (b_q.size() != 0) begin n_fail++; $display("FAIL wide_queue_left: got %0d expected 0", b_q.size()); end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_write_busy();
    test_reset_mid();
    test_back_to_back();
    test_slow_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
